// File: rtl/controle_varredura_display_if.sv
// -----------------------------------------------------------------------------
// controle_varredura_display_if
// Bus between the scan controller and its user/display side.
//   Valores   : packed BCD frame, digit 0 (rightmost) in bits [3:0]
//   Carregar  : one-cycle strobe capturing Valores
//   Habilita  : scan enable, 0 blanks the display
//   DigitoBCD : nibble for the shared BCD-to-segment decoder (4'hF = blank)
//   Anodo     : active-low digit enables, one-cold while a digit is shown
//   Indice    : current digit slot
//   Fim       : one-cycle pulse at frame wrap
//   Pendente  : a captured frame waits for the next frame boundary
// Modports: slave = scan controller, master = user side.
// -----------------------------------------------------------------------------
interface controle_varredura_display_if #(
    parameter int NUM_DIGITOS = 4
);
    localparam int IW = $clog2(NUM_DIGITOS);

    logic [4*NUM_DIGITOS-1:0] Valores;
    logic                     Carregar;
    logic                     Habilita;
    logic [3:0]               DigitoBCD;
    logic [NUM_DIGITOS-1:0]   Anodo;
    logic [IW-1:0]            Indice;
    logic                     Fim;
    logic                     Pendente;

    modport slave (
        input  Valores, Carregar, Habilita,
        output DigitoBCD, Anodo, Indice, Fim, Pendente
    );

    modport master (
        output Valores, Carregar, Habilita,
        input  DigitoBCD, Anodo, Indice, Fim, Pendente
    );
endinterface

// File: rtl/controle_varredura_display.sv
// -----------------------------------------------------------------------------
// controle_varredura_display
// Time-multiplexed scan controller for common-anode 7-segment digits sharing a
// single BCD decoder. Each digit slot lasts DIV_SCAN cycles: the first DEAD
// cycles are blank (anti-ghosting), the rest show the digit. New frames are
// staged and only become active at a frame boundary (wrap or enable), so a
// displayed frame never mixes old and new digits.
// Ports:
//   Clock : rising-edge clock
//   Reset : asynchronous, active-high reset
//   bus   : controle_varredura_display_if.slave (Valores, Carregar, Habilita,
//           DigitoBCD, Anodo, Indice, Fim, Pendente)
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 always shown). Default build shows every nibble as stored.
// All outputs are registered.
// -----------------------------------------------------------------------------
module controle_varredura_display #(
    parameter int NUM_DIGITOS = 4,
    parameter int DIV_SCAN    = 50000,
    parameter int DEAD        = 16
) (
    input  logic                            Clock,
    input  logic                            Reset,
    controle_varredura_display_if.slave     bus
);
    localparam int IW = $clog2(NUM_DIGITOS);
    localparam int CW = $clog2(DIV_SCAN);
    localparam int VW = 4 * NUM_DIGITOS;

    localparam logic [CW-1:0] ULTIMO_CONT = CW'(DIV_SCAN - 1);
    localparam logic [CW-1:0] FIM_APAGA   = CW'(DEAD);
    localparam logic [IW-1:0] ULTIMO_IDX  = IW'(NUM_DIGITOS - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        APAGA  = 2'd1,
        MOSTRA = 2'd2
    } estado_t;

    // With no dead time a slot starts directly in MOSTRA.
    localparam estado_t INICIO_SLOT = (DEAD == 0) ? MOSTRA : APAGA;

    estado_t                estado_r,   estado_s;
    logic [CW-1:0]          cont_r,     cont_s;
    logic [CW-1:0]          cont_inc_s;
    logic [IW-1:0]          indice_r,   indice_s;
    logic [VW-1:0]          staging_r,  staging_s;
    logic [VW-1:0]          active_r,   active_s;
    logic                   pendente_r, pendente_s;
    logic [NUM_DIGITOS-1:0] anodo_r,    anodo_s;
    logic [3:0]             digito_r,   digito_s;
    logic                   fim_r,      fim_s;
    logic                   fronteira_s;

`ifdef LEADING_ZERO_BLANK_EN
    // True when nibble idx and every higher nibble of v are zero.
    function automatic logic zeros_acima(input logic [VW-1:0] v, input logic [IW-1:0] idx);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if ((IW'(i) >= idx) && (v[4*i +: 4] != 4'h0)) begin
                r = 1'b0;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction
`endif

    assign cont_inc_s = cont_r + CW'(1);

    // Next state, frame buffers and the output values they imply.
    always_comb begin
        estado_s    = estado_r;
        cont_s      = cont_r;
        indice_s    = indice_r;
        staging_s   = staging_r;
        active_s    = active_r;
        pendente_s  = pendente_r;
        fim_s       = 1'b0;
        fronteira_s = 1'b0;
        anodo_s     = {NUM_DIGITOS{1'b1}};
        digito_s    = 4'hF;

        if (!bus.Habilita) begin
            estado_s = OCIOSO;
            cont_s   = {CW{1'b0}};
            indice_s = {IW{1'b0}};
        end else begin
            case (estado_r)
                OCIOSO: begin
                    // Entering the scan is a frame boundary, but never a wrap.
                    estado_s    = INICIO_SLOT;
                    cont_s      = {CW{1'b0}};
                    indice_s    = {IW{1'b0}};
                    fronteira_s = 1'b1;
                end
                APAGA: begin
                    cont_s = cont_inc_s;
                    if (cont_inc_s == FIM_APAGA) begin
                        estado_s = MOSTRA;
                    end else begin
                        estado_s = APAGA;
                    end
                end
                MOSTRA: begin
                    if (cont_r == ULTIMO_CONT) begin
                        estado_s = INICIO_SLOT;
                        cont_s   = {CW{1'b0}};
                        if (indice_r == ULTIMO_IDX) begin
                            indice_s    = {IW{1'b0}};
                            fronteira_s = 1'b1;
                            fim_s       = 1'b1;
                        end else begin
                            indice_s = indice_r + IW'(1);
                        end
                    end else begin
                        cont_s = cont_inc_s;
                    end
                end
                default: begin
                    estado_s = OCIOSO;
                    cont_s   = {CW{1'b0}};
                    indice_s = {IW{1'b0}};
                end
            endcase
        end

        // A strobe coinciding with a boundary bypasses staging entirely.
        if (fronteira_s) begin
            if (bus.Carregar) begin
                staging_s  = bus.Valores;
                active_s   = bus.Valores;
                pendente_s = 1'b0;
            end else if (pendente_r) begin
                active_s   = staging_r;
                pendente_s = 1'b0;
            end else begin
                pendente_s = 1'b0;
            end
        end else if (bus.Carregar) begin
            staging_s  = bus.Valores;
            pendente_s = 1'b1;
        end else begin
            pendente_s = pendente_r;
        end

        // Outputs derive from the next state so they can be registered.
        if (estado_s == MOSTRA) begin
            anodo_s[indice_s] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if ((indice_s != {IW{1'b0}}) && zeros_acima(active_s, indice_s)) begin
                digito_s = 4'hF;
            end else begin
                digito_s = active_s[4*indice_s +: 4];
            end
`else
            digito_s = active_s[4*indice_s +: 4];
`endif
        end else begin
            anodo_s  = {NUM_DIGITOS{1'b1}};
            digito_s = 4'hF;
        end
    end

    // FSM state, frame buffers and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado_r   <= OCIOSO;
            cont_r     <= {CW{1'b0}};
            indice_r   <= {IW{1'b0}};
            staging_r  <= {VW{1'b0}};
            active_r   <= {VW{1'b0}};
            pendente_r <= 1'b0;
            anodo_r    <= {NUM_DIGITOS{1'b1}};
            digito_r   <= 4'hF;
            fim_r      <= 1'b0;
        end else begin
            estado_r   <= estado_s;
            cont_r     <= cont_s;
            indice_r   <= indice_s;
            staging_r  <= staging_s;
            active_r   <= active_s;
            pendente_r <= pendente_s;
            anodo_r    <= anodo_s;
            digito_r   <= digito_s;
            fim_r      <= fim_s;
        end
    end

    assign bus.Anodo     = anodo_r;
    assign bus.DigitoBCD = digito_r;
    assign bus.Indice    = indice_r;
    assign bus.Fim       = fim_r;
    assign bus.Pendente  = pendente_r;

endmodule

// File: tb/tb_controle_varredura_display.sv
// -----------------------------------------------------------------------------
// tb_controle_varredura_display
// Directed bench for controle_varredura_display with NUM_DIGITOS=4,
// DIV_SCAN=8, DEAD=2. Expected values are hand-derived: each slot is
// 2 blank cycles followed by 6 cycles showing one digit.
// -----------------------------------------------------------------------------
module tb_controle_varredura_display;
    localparam int N    = 4;
    localparam int DIV  = 8;
    localparam int DT   = 2;

    logic Clock;
    logic Reset;
    int   errors;
    int   checks;

    controle_varredura_display_if #(.NUM_DIGITOS(N)) bus ();

    controle_varredura_display #(
        .NUM_DIGITOS (N),
        .DIV_SCAN    (DIV),
        .DEAD        (DT)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check slot positions p0..p1 of digit idx; ticks after each position.
    task automatic verifica_slot(input int idx, input logic [3:0] dig, input logic fim0,
                                 input int p0, input int p1);
        for (int p = p0; p <= p1; p++) begin
            logic [3:0] um;
            logic [3:0] an_exp;
            logic [3:0] dg_exp;
            logic [1:0] ix;
            um = 4'b0001;
            ix = idx[1:0];
            if (p < DT) begin
                an_exp = 4'hF;
                dg_exp = 4'hF;
            end else begin
                an_exp = ~(um << idx);
                dg_exp = dig;
            end
            chk($sformatf("anodo d%0d p%0d", idx, p), {12'h000, bus.Anodo}, {12'h000, an_exp});
            chk($sformatf("digito d%0d p%0d", idx, p), {12'h000, bus.DigitoBCD}, {12'h000, dg_exp});
            chk($sformatf("indice d%0d p%0d", idx, p), {14'h0000, bus.Indice}, {14'h0000, ix});
            chk($sformatf("fim d%0d p%0d", idx, p), {15'h0000, bus.Fim},
                {15'h0000, (p == 0) ? fim0 : 1'b0});
            tick();
        end
    endtask

    initial begin
        logic [3:0] lz;
        errors = 0;
        checks = 0;
        Reset        = 1'b1;
        bus.Valores  = 16'h0000;
        bus.Carregar = 1'b0;
        bus.Habilita = 1'b0;

        // Reset state
        tick();
        chk("rst anodo", {12'h000, bus.Anodo}, 16'h000F);
        chk("rst digito", {12'h000, bus.DigitoBCD}, 16'h000F);
        chk("rst indice", {14'h0000, bus.Indice}, 16'h0000);
        chk("rst fim", {15'h0000, bus.Fim}, 16'h0000);
        chk("rst pendente", {15'h0000, bus.Pendente}, 16'h0000);
        Reset = 1'b0;

        // 1. Scan sequence: load while disabled, then enable
        bus.Valores  = 16'h1234;
        bus.Carregar = 1'b1;
        tick();
        bus.Carregar = 1'b0;
        chk("t1 pendente set", {15'h0000, bus.Pendente}, 16'h0001);
        chk("t1 idle anodo", {12'h000, bus.Anodo}, 16'h000F);
        bus.Habilita = 1'b1;
        tick();
        chk("t1 pendente clr", {15'h0000, bus.Pendente}, 16'h0000);
        verifica_slot(0, 4'h4, 1'b0, 0, 7);
        verifica_slot(1, 4'h3, 1'b0, 0, 7);
        verifica_slot(2, 4'h2, 1'b0, 0, 7);
        verifica_slot(3, 4'h1, 1'b0, 0, 7);
        verifica_slot(0, 4'h4, 1'b1, 0, 7);

        // 2. Mid-frame update during digit 1
        bus.Valores  = 16'h5678;
        bus.Carregar = 1'b1;
        tick();
        bus.Carregar = 1'b0;
        chk("t2 pendente", {15'h0000, bus.Pendente}, 16'h0001);
        verifica_slot(1, 4'h3, 1'b0, 1, 7);
        verifica_slot(2, 4'h2, 1'b0, 0, 7);
        verifica_slot(3, 4'h1, 1'b0, 0, 7);
        chk("t2 pendente clr", {15'h0000, bus.Pendente}, 16'h0000);
        verifica_slot(0, 4'h8, 1'b1, 0, 7);
        verifica_slot(1, 4'h7, 1'b0, 0, 7);
        verifica_slot(2, 4'h6, 1'b0, 0, 7);
        verifica_slot(3, 4'h5, 1'b0, 0, 6);

        // 3a. Strobe in the wrap cycle goes straight to active
        bus.Valores  = 16'h9999;
        bus.Carregar = 1'b1;
        verifica_slot(3, 4'h5, 1'b0, 7, 7);
        bus.Carregar = 1'b0;
        chk("t3a pendente", {15'h0000, bus.Pendente}, 16'h0000);
        // 3b. Two strobes in one frame: last wins
        bus.Valores  = 16'h1111;
        bus.Carregar = 1'b1;
        verifica_slot(0, 4'h9, 1'b1, 0, 0);
        bus.Carregar = 1'b0;
        verifica_slot(0, 4'h9, 1'b0, 1, 3);
        bus.Valores  = 16'h2222;
        bus.Carregar = 1'b1;
        verifica_slot(0, 4'h9, 1'b0, 4, 4);
        bus.Carregar = 1'b0;
        chk("t3b pendente", {15'h0000, bus.Pendente}, 16'h0001);
        verifica_slot(0, 4'h9, 1'b0, 5, 7);
        verifica_slot(1, 4'h9, 1'b0, 0, 7);
        verifica_slot(2, 4'h9, 1'b0, 0, 7);
        verifica_slot(3, 4'h9, 1'b0, 0, 7);
        verifica_slot(0, 4'h2, 1'b1, 0, 7);

        // 4. Disable mid-slot with pending data, then re-enable
        verifica_slot(1, 4'h2, 1'b0, 0, 0);
        bus.Valores  = 16'h4321;
        bus.Carregar = 1'b1;
        verifica_slot(1, 4'h2, 1'b0, 1, 1);
        bus.Carregar = 1'b0;
        verifica_slot(1, 4'h2, 1'b0, 2, 7);
        verifica_slot(2, 4'h2, 1'b0, 0, 3);
        bus.Habilita = 1'b0;
        tick();
        chk("t4 off anodo", {12'h000, bus.Anodo}, 16'h000F);
        chk("t4 off digito", {12'h000, bus.DigitoBCD}, 16'h000F);
        chk("t4 off indice", {14'h0000, bus.Indice}, 16'h0000);
        chk("t4 off pendente", {15'h0000, bus.Pendente}, 16'h0001);
        tick();
        chk("t4 idle fim", {15'h0000, bus.Fim}, 16'h0000);
        bus.Habilita = 1'b1;
        tick();
        chk("t4 on pendente", {15'h0000, bus.Pendente}, 16'h0000);
        verifica_slot(0, 4'h1, 1'b0, 0, 7);
        verifica_slot(1, 4'h2, 1'b0, 0, 7);
        verifica_slot(2, 4'h3, 1'b0, 0, 7);
        verifica_slot(3, 4'h4, 1'b0, 0, 7);
        verifica_slot(0, 4'h1, 1'b1, 0, 7);

        // 5. Asynchronous reset between edges during MOSTRA
        verifica_slot(1, 4'h2, 1'b0, 0, 3);
        #2;
        Reset = 1'b1;
        #1;
        chk("t5 async anodo", {12'h000, bus.Anodo}, 16'h000F);
        chk("t5 async digito", {12'h000, bus.DigitoBCD}, 16'h000F);
        chk("t5 async indice", {14'h0000, bus.Indice}, 16'h0000);
        chk("t5 async pendente", {15'h0000, bus.Pendente}, 16'h0000);
        tick();
        chk("t5 held fim", {15'h0000, bus.Fim}, 16'h0000);
        tick();
        chk("t5 held anodo", {12'h000, bus.Anodo}, 16'h000F);
        Reset = 1'b0;
        tick();
        verifica_slot(0, 4'h0, 1'b0, 0, 7);
        verifica_slot(1, 4'h0, 1'b0, 0, 7);

        // 6. Leading-zero handling with 16'h0070
`ifdef LEADING_ZERO_BLANK_EN
        lz = 4'hF;
`else
        lz = 4'h0;
`endif
        bus.Habilita = 1'b0;
        bus.Valores  = 16'h0070;
        bus.Carregar = 1'b1;
        tick();
        bus.Carregar = 1'b0;
        chk("t6 pendente", {15'h0000, bus.Pendente}, 16'h0001);
        bus.Habilita = 1'b1;
        tick();
        verifica_slot(0, 4'h0, 1'b0, 0, 7);
        verifica_slot(1, 4'h7, 1'b0, 0, 7);
        verifica_slot(2, lz, 1'b0, 0, 7);
        verifica_slot(3, lz, 1'b0, 0, 7);
        verifica_slot(0, 4'h0, 1'b1, 0, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
